// File: rtl/permutation_xor.sv
// permutation_xor: one ASCON permutation round per enabled clock edge.
// Optional tag tap on x3/x4 enabled by PERMUTATION_XOR_TAG_EN.
package ascon_pack;
  typedef logic [0:4][63:0] type_state;
endpackage

module permutation_xor
  import ascon_pack::*;
(
  input  logic           clock_i,
  input  logic           rst_i,
  input  type_state      S_i,
  input  logic           init_state_i,
  input  logic [3:0]     round_i,
  input  logic           ctrl_1_i,
  input  logic [127:0]   data_1_i,
  input  logic           ctrl_2_i,
  input  logic [191:0]   data_2_i,
  input  logic           write_enable_i,
  output logic [127:0]   cipher_o,
  output logic [127:0]   tag_o
);

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14,
    5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12,
    5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E,
    5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19,
    5'h16, 5'h0A, 5'h0F, 5'h17
  };

  type_state state_q;
  type_state in_st;
  type_state rate_st;
  type_state cst_st;
  type_state sbx_st;
  type_state lin_st;
  type_state cap_st;

  logic [7:0] rc;
  logic [4:0] col;
  logic [4:0] sub;

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input logic [5:0]  n
  );
    return (v >> n) | (v << (7'd64 - {1'b0, n}));
  endfunction

  // datapath source: external load or the round register
  assign in_st = init_state_i ? S_i : state_q;

  // rate XOR on x0/x1 (absorb / encrypt)
  always_comb begin
    rate_st = in_st;
    if (ctrl_1_i) begin
      rate_st[0] = in_st[0] ^ data_1_i[127:64];
      rate_st[1] = in_st[1] ^ data_1_i[63:0];
    end
  end

  assign cipher_o = {rate_st[0], rate_st[1]};

  // round constant {~r, r} into the low byte of x2
  assign rc = {~round_i, round_i};

  always_comb begin
    cst_st    = rate_st;
    cst_st[2] = rate_st[2] ^ {56'h0, rc};
  end

  // 5-bit S-box applied to every bit column, x0 as MSB
  always_comb begin
    sbx_st = '0;
    col    = '0;
    sub    = '0;
    for (int j = 0; j < 64; j++) begin
      col = {cst_st[0][j], cst_st[1][j],
             cst_st[2][j], cst_st[3][j],
             cst_st[4][j]};
      sub = SBOX[col];
      sbx_st[0][j] = sub[4];
      sbx_st[1][j] = sub[3];
      sbx_st[2][j] = sub[2];
      sbx_st[3][j] = sub[1];
      sbx_st[4][j] = sub[0];
    end
  end

  // per-word linear diffusion
  always_comb begin
    lin_st[0] = sbx_st[0]
              ^ ror(sbx_st[0], 6'd19)
              ^ ror(sbx_st[0], 6'd28);
    lin_st[1] = sbx_st[1]
              ^ ror(sbx_st[1], 6'd61)
              ^ ror(sbx_st[1], 6'd39);
    lin_st[2] = sbx_st[2]
              ^ ror(sbx_st[2], 6'd1)
              ^ ror(sbx_st[2], 6'd6);
    lin_st[3] = sbx_st[3]
              ^ ror(sbx_st[3], 6'd10)
              ^ ror(sbx_st[3], 6'd17);
    lin_st[4] = sbx_st[4]
              ^ ror(sbx_st[4], 6'd7)
              ^ ror(sbx_st[4], 6'd41);
  end

  // capacity XOR on x2..x4 (key add at init/final)
  always_comb begin
    cap_st = lin_st;
    if (ctrl_2_i) begin
      cap_st[2] = lin_st[2] ^ data_2_i[191:128];
      cap_st[3] = lin_st[3] ^ data_2_i[127:64];
      cap_st[4] = lin_st[4] ^ data_2_i[63:0];
    end
  end

`ifdef PERMUTATION_XOR_TAG_EN
  assign tag_o = {cap_st[3], cap_st[4]};
`else
  assign tag_o = 128'h0;
`endif

  // state register: reset wins, otherwise load on enable
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else if (write_enable_i) begin
      state_q <= cap_st;
    end
  end

endmodule

// File: tb/tb_permutation_xor.sv
// tb_permutation_xor: directed + random checks of one ASCON round
// against a bitsliced reference model.
module tb_permutation_xor;
  import ascon_pack::*;

  logic         clk = 1'b0;
  logic         rst;
  type_state    s_in;
  logic         init;
  logic [3:0]   rnd;
  logic         c1;
  logic [127:0] d1;
  logic         c2;
  logic [191:0] d2;
  logic         we;
  logic [127:0] cipher;
  logic [127:0] tag;

  int checks = 0;
  int errors = 0;

  logic [319:0] ms;
  logic [319:0] snap;
  logic [319:0] s_key;

  always #5 clk = ~clk;

  permutation_xor dut (
    .clock_i        (clk),
    .rst_i          (rst),
    .S_i            (s_in),
    .init_state_i   (init),
    .round_i        (rnd),
    .ctrl_1_i       (c1),
    .data_1_i       (d1),
    .ctrl_2_i       (c2),
    .data_2_i       (d2),
    .write_enable_i (we),
    .cipher_o       (cipher),
    .tag_o          (tag)
  );

  function automatic logic [63:0] rot(
    input logic [63:0] v,
    input int n
  );
    logic [127:0] w;
    w = {v, v} >> n;
    return w[63:0];
  endfunction

  function automatic logic [319:0] model(
    input  logic [319:0] s,
    input  logic [3:0]   r,
    input  logic         a1,
    input  logic [127:0] b1,
    input  logic         a2,
    input  logic [191:0] b2,
    output logic [127:0] rate
  );
    logic [63:0] x [5];
    logic [63:0] t [5];
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    if (a1) begin
      x[0] ^= b1[127:64];
      x[1] ^= b1[63:0];
    end
    rate = {x[0], x[1]};
    x[2] ^= 64'((15 - int'(r)) * 16 + int'(r));
    x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i+1)%5];
    for (int i = 0; i < 5; i++) x[i] ^= t[(i+1)%5];
    x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
    for (int i = 0; i < 5; i++)
      x[i] = x[i] ^ rot(x[i], ra[i]) ^ rot(x[i], rb[i]);
    if (a2) begin
      x[2] ^= b2[191:128];
      x[3] ^= b2[127:64];
      x[4] ^= b2[63:0];
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(
    input string        nm,
    input logic [319:0] obs,
    input logic [319:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic cycle(input string nm);
    logic [319:0] nxt;
    logic [127:0] rt;
    logic [127:0] et;
    nxt = model(init ? 320'(s_in) : ms, rnd, c1, d1, c2, d2, rt);
`ifdef PERMUTATION_XOR_TAG_EN
    et = nxt[127:0];
`else
    et = 128'h0;
`endif
    @(negedge clk);
    chk({nm, "_cipher"}, 320'(cipher), 320'(rt));
    chk({nm, "_tag"}, 320'(tag), 320'(et));
    @(posedge clk);
    if (rst) ms = '0;
    else if (we) ms = nxt;
    #1;
    chk({nm, "_state"}, 320'(dut.state_q), ms);
  endtask

  task automatic idle();
    rst = 0; init = 0; rnd = 0; we = 0;
    c1 = 0; d1 = '0; c2 = 0; d2 = '0;
  endtask

  initial begin
    ms = 'x;
    idle();
    s_in = '0;
    rst = 1;
    @(posedge clk); #1;
    ms = '0;
    chk("reset_state", 320'(dut.state_q), 320'h0);
    rst = 0;

    // zero state through the round after reset
    cycle("after_reset");
    chk("after_reset_hold", 320'(dut.state_q), 320'h0);

    // zero-state single round, known answer
    init = 1; we = 1; rnd = 0; s_in = '0;
    cycle("zero_round");
    chk("zero_kat", 320'(dut.state_q), {
      64'h001E0F00000000F0, 64'h00000001E0000770,
      64'h3FFFFFFFFFFFFF74, 64'h3C780000000000F0,
      64'h0});

    // full p12 from the AEAD init vector
    s_key = {64'h00001000808C0001, 64'h6CB10AD9CA912F80,
             64'h691AED630E81901F, 64'h0C4C36A20853217C,
             64'h46487B3E06D9D7A8};
    s_in = s_key;
    for (int r = 0; r < 12; r++) begin
      init = (r == 0);
      rnd  = 4'(r);
      cycle("p12");
    end
    init = 0;

    // capacity XOR with key words
    c2 = 1; rnd = 4;
    d2 = {64'h0, s_key[255:192], s_key[191:128]};
    cycle("cap_xor");
    c2 = 0;

    // rate XOR without write
    c1 = 1; we = 0; rnd = 7;
    d1 = 128'h0123456789ABCDEFFEDCBA9876543210;
    snap = 320'(dut.state_q);
    cycle("rate_xor");
    chk("rate_hold", 320'(dut.state_q), snap);
    chk("rate_direct", 320'(cipher), 320'(snap[319:192] ^ d1));

    // both XORs in one round
    we = 1; c1 = 1; c2 = 1;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rnd = 4'($urandom_range(0, 15));
    cycle("both_xor");
    c1 = 0; c2 = 0;

    // reset beats write enable
    rst = 1; we = 1; init = 1;
    s_in = {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
    cycle("rst_prio");
    chk("rst_prio_zero", 320'(dut.state_q), 320'h0);
    idle();
    cycle("post_rst");

    // load something then hold for three cycles
    init = 1; we = 1; rnd = 2;
    cycle("hold_load");
    init = 0; we = 0;
    snap = 320'(dut.state_q);
    for (int k = 0; k < 3; k++) begin
      rnd = 4'(k * 5 + 3);
      cycle("hold");
      chk("hold_const", 320'(dut.state_q), snap);
    end

    // p8 from a random state
    s_in = {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
    we = 1;
    for (int r = 4; r < 12; r++) begin
      init = (r == 4);
      rnd  = 4'(r);
      cycle("p8");
    end

    // random mix of all controls, rounds 12..15 included
    for (int k = 0; k < 40; k++) begin
      rst  = ($urandom_range(0, 9) == 0);
      init = ($urandom_range(0, 3) == 0);
      we   = ($urandom_range(0, 3) != 0);
      c1   = $urandom_range(0, 1) == 1;
      c2   = $urandom_range(0, 1) == 1;
      rnd  = 4'($urandom_range(0, 15));
      d1   = {$urandom, $urandom, $urandom, $urandom};
      d2   = {$urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom};
      s_in = {$urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
